// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared datapath widths and the data-memory responder state encoding
package dp_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between MEM stage and data memory
interface data_mem_responder_if #(
  parameter int DATA_W = dp_pkg::DATA_W,
  parameter int ADDR_W = dp_pkg::ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// rtl/data_mem_responder_mem_array.sv - DEPTH x DATA_W register array, sync write, comb read, async clear
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              sysclk,
  input  logic              sysrst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Unimplemented addresses read as zero rather than aliasing.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory target with programmable access latency
module data_mem_responder #(
  parameter int DATA_W  = dp_pkg::DATA_W,
  parameter int ADDR_W  = dp_pkg::ADDR_W,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2
) (
  input logic                 sysclk,
  input logic                 sysrst_n,
  data_mem_responder_if.slave bus
);

  import dp_pkg::state_t;
  import dp_pkg::IDLE;
  import dp_pkg::BUSY;
  import dp_pkg::RESP;

  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              capture, load_rsp, clear_rsp, mem_we, in_range;

  assign in_range = (32'(addr_q) < DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    load_rsp  = 1'b0;
    clear_rsp = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          capture = 1'b1;
        end
      end
      BUSY: begin
        // Write commits on the same edge the response is registered.
        if (cnt_q == '0) begin
          state_d  = RESP;
          load_rsp = 1'b1;
          mem_we   = we_q & in_range;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d   = IDLE;
          clear_rsp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (load_rsp) begin
        rdata_q <= (!we_q && in_range) ? mem_rdata : '0;
        err_q   <= !in_range;
      end else if (clear_rsp) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .sysclk   (sysclk),
    .sysrst_n (sysrst_n),
    .we       (mem_we),
    .waddr    (addr_q),
    .wdata    (wdata_q),
    .raddr    (addr_q),
    .rdata    (mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the 8-bit datapath's MEM stage. It is the target end of the datapath's memory access and replaces the unimplemented memory instance.
- Accepts one read or write request at a time over a valid/ready handshake and waits a programmable access latency.
- Returns read data, or a write acknowledge, over a second valid/ready handshake.
- Storage is an internal register array.

Parameters:
- DATA_W, 8, data word width (matches datapath register width)
- ADDR_W, 3, address width (matches 3-bit aux/immediate field)
- DEPTH, 8, number of implemented words; must be >= 1 and <= 2**ADDR_W
- LATENCY, 2, cycles between request acceptance and response valid; must be >= 1

Ports:
- sysclk  in  1  system clock, rising edge
- sysrst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  datapath accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  address >= DEPTH

Behaviour:
- Clock and reset: one clock, sysclk. Reset sysrst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Latency counter = 0; all DEPTH memory words = 0.
- Request acceptance: a request is accepted on a rising edge with req_valid & req_ready. The responder latches we, addr and wdata at that edge.
- Outstanding requests: at most one. req_ready = 1 only in IDLE. No combinational path from req_valid to req_ready.
- FSM states:
  - IDLE: on accept -> BUSY, counter loaded with LATENCY-1.
  - BUSY: counter decrements each cycle. When counter == 0 the response is registered, state -> RESP, and rsp_valid rises on that edge.
  - Timing: rsp_valid asserts exactly LATENCY cycles after the accept edge. With LATENCY=1 that is the edge after accept.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready at a rising edge; then -> IDLE and rsp_valid = 0.
  - Back-to-back: req_ready returns in the cycle after the handshake, so the next request can be accepted one cycle after the response completes. No same-cycle bypass.
- Write: the array update occurs at the BUSY->RESP edge, and only if addr < DEPTH. The response carries rsp_rdata = 0.
- Read: rsp_rdata = mem[addr] sampled at the BUSY->RESP edge. A read immediately following a write to the same address returns the new data.
- Error: for addr >= DEPTH, rsp_err = 1, rsp_rdata = 0, and no write occurs. rsp_err is only meaningful while rsp_valid = 1 and is 0 otherwise.
- rsp_ready: may be held high permanently. While in RESP, rsp_ready low stalls indefinitely with no data change.
- req_* in BUSY/RESP: ignored. Latched values are not disturbed.
- Reset mid-operation: an asynchronous assert from any state forces IDLE and clears the array. A pending response is discarded with no handshake.
- Width rules: the counter is sized clog2(LATENCY)+1 bits and never wraps below 0.

Decomposition:
- Shared package (dp_pkg) holds:
  - DATA_W = 8 and ADDR_W = 3, shared with register file and ALU;
  - a state enum {IDLE, BUSY, RESP} as a 2-bit encoding.
- One natural sub-module, mem_array: DEPTH x DATA_W register array.
  - One synchronous write port with write enable, and one combinational read port.
  - Asynchronous clear on sysrst_n.
- The FSM, counter and response registers stay in data_mem_responder.

Test Plan:
1. Reset then idle: sysrst_n low 3 cycles, release.
   -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0; a read of addr 5 returns 0x00, rsp_err = 0.
2. Write then read, LATENCY=2:
   - Write addr 3 = 0xA5 -> rsp_valid exactly 2 cycles after accept, rsp_rdata = 0.
   - Read addr 3 -> rsp_rdata = 0xA5.
3. Backpressure: read addr 3 with rsp_ready low for 5 cycles.
   -> rsp_valid stays 1, rsp_rdata stays 0xA5 throughout, req_ready = 0; rsp_ready high -> IDLE next cycle.
4. Out of range with DEPTH=6:
   - Write addr 7 = 0x3C -> rsp_err = 1.
   - Read addr 7 -> rsp_err = 1, rsp_rdata = 0.
   - All of addrs 0-5 are unchanged.
5. Back-to-back with rsp_ready tied high, LATENCY=1: writes to addrs 0..7 with data 0x10+addr, then reads.
   - Each response arrives 1 cycle after accept; each new accept occurs 1 cycle after the previous handshake.
   - Reads return 0x10..0x17.
6. Reset mid-operation: accept write addr 2 = 0xFF, assert sysrst_n in BUSY.
   -> rsp_valid never asserts, state IDLE; a later read of addr 2 returns 0x00.
